// File: rtl/sram_array_driver.sv
// sram_array_driver: request-side controller for a 128x4x21 single-port cache array.
// Zero-fills the array after reset, then serves one read or write at a time.
module sram_array_driver #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int WAYS   = 4,
  parameter int WAY_W  = 21,
  parameter int DATA_W = WAYS * WAY_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [WAYS-1:0]   req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_clk,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [WAYS-1:0]   RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD,
    RESP
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;

  assign RW0_clk = clock;

  // State, fill counter, init flag and the captured read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) init_done <= 1'b1;
      end
      if (state == RD) resp_rdata <= RW0_rdata;
    end
  end

  // Next state and array port decode; idle array pins are held at 0.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_addr   = '0;
    RW0_wdata  = '0;
    RW0_wmask  = '0;
    unique case (state)
      INIT: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = cnt;
        RW0_wmask = '1;
        if (cnt == LAST) state_nx = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          RW0_en   = 1'b1;
          RW0_addr = req_addr;
          if (req_write) begin
            RW0_wmode = 1'b1;
            RW0_wdata = req_wdata;
            RW0_wmask = req_wmask;
          end else begin
            state_nx = RD;
          end
        end
      end
      RD: state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

endmodule

// File: tb/tb_sram_array_driver.sv
// tb_sram_array_driver: directed table, corner sequences and random traffic
// against a behavioural array model and a reference memory.
module tb_sram_array_driver;

  localparam int AW = 7;
  localparam int DW = 84;
  localparam int NW = 4;
  localparam int WW = 21;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init_done;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NW-1:0] req_wmask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_clk;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [NW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram [128];
  logic [DW-1:0] ref_mem [128];

  sram_array_driver dut (
    .clock      (clock),
    .reset      (reset),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_clk    (RW0_clk),
    .RW0_wmode  (RW0_wmode),
    .RW0_wdata  (RW0_wdata),
    .RW0_wmask  (RW0_wmask),
    .RW0_rdata  (RW0_rdata)
  );

  always #5 clock = ~clock;

  // Array macro: masked write at the edge, registered read, garbage otherwise.
  always @(posedge RW0_clk) begin
    logic [95:0] junk;
    junk = {$urandom, $urandom, $urandom};
    if (RW0_en && RW0_wmode) begin
      for (int w = 0; w < NW; w++)
        if (RW0_wmask[w]) sram[RW0_addr][w*WW +: WW] <= RW0_wdata[w*WW +: WW];
      RW0_rdata <= junk[DW-1:0];
    end else if (RW0_en) begin
      RW0_rdata <= sram[RW0_addr];
    end else begin
      RW0_rdata <= junk[DW-1:0];
    end
  end

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old,
                                          logic [DW-1:0] d,
                                          logic [NW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int w = 0; w < NW; w++)
      if (m[w]) r[w*WW +: WW] = d[w*WW +: WW];
    return r;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic do_sweep();
    reset = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      check("sweep",
            {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, req_ready,
             init_done, |RW0_wdata},
            {1'b1, 1'b1, 7'(i), 4'hF, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clock);
    check("init_end", {init_done, RW0_en, req_ready}, 3'b101);
    for (int a = 0; a < 128; a++) ref_mem[a] = '0;
  endtask

  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d,
                          logic [NW-1:0] m);
    @(negedge clock);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    #1;
    check("wr_issue", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask},
          {1'b1, 1'b1, a, m});
    check("wr_data", RW0_wdata, d);
    @(posedge clock);
    #1 req_valid = 1'b0;
    ref_mem[a] = merge(ref_mem[a], d, m);
  endtask

  task automatic do_read(logic [AW-1:0] a, string name);
    @(negedge clock);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_wdata = {3{28'hFFFFFFF}};
    req_wmask = 4'hF;
    #1;
    check("rd_issue", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, |RW0_wdata},
          {1'b1, 1'b0, a, 4'h0, 1'b0});
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rd_t1", {resp_valid, req_ready, RW0_en}, 3'b000);
    @(negedge clock);
    check("rd_t2_valid", {resp_valid, req_ready, RW0_en}, 3'b100);
    check(name, resp_rdata, ref_mem[a]);
    @(negedge clock);
    check("rd_t3_ready", {resp_valid, req_ready}, 2'b01);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NW-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;

  localparam logic [DW-1:0] PAT = 84'h123456789ABCDEF012345;
  localparam logic [DW-1:0] W02 = {21'h0, 21'h1FFFFF, 21'h0, 21'h1FFFFF};

  initial begin
    vec_t tbl [7];
    logic [DW-1:0] held;
    logic [95:0]   rnd;

    tbl[0] = '{1'b0, 7'h05, '0, 4'h0, '0};
    tbl[1] = '{1'b1, 7'h2A, PAT, 4'hF, '0};
    tbl[2] = '{1'b0, 7'h2A, '0, 4'h0, PAT};
    tbl[3] = '{1'b1, 7'h2A, '1, 4'b0101, '0};
    tbl[4] = '{1'b0, 7'h2A, '0, 4'h0, PAT | W02};
    tbl[5] = '{1'b1, 7'h2A, '0, 4'h0, '0};
    tbl[6] = '{1'b0, 7'h2A, '0, 4'h0, PAT | W02};

    @(negedge clock);
    check("reset_state", {init_done, req_ready, resp_valid, resp_rdata},
          {3'b000, 84'h0});
    do_sweep();

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      end else begin
        check("tbl_model", ref_mem[tbl[i].addr], tbl[i].exp);
        do_read(tbl[i].addr, "tbl_read");
      end
    end

    // Back-pressure with a request waiting behind the response.
    @(negedge clock);
    wait_ready();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 7'h2A;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("bp_valid", resp_valid, 1'b1);
    held = resp_rdata;
    check("bp_data", held, PAT | W02);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'h03;
    req_wdata = PAT;
    req_wmask = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_hold", {resp_valid, req_ready, RW0_en}, 3'b100);
      check("bp_stable", resp_rdata, held);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("bp_accept", {resp_valid, req_ready, RW0_en, RW0_wmode}, 4'b0111);
    @(posedge clock);
    #1 req_valid = 1'b0;
    ref_mem[3] = PAT;
    do_read(7'h03, "bp_followup");

    // Write then read the same address on the very next cycle.
    do_write(7'h11, ~PAT, 4'hF);
    do_read(7'h11, "wr_then_rd");

    // Randomised traffic over a small address window.
    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_write(7'($urandom_range(0, 15)), rnd[DW-1:0], 4'($urandom));
      else
        do_read(7'($urandom_range(0, 15)), "rand_read");
    end

    // Reset while a response is being held.
    @(negedge clock);
    wait_ready();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 7'h2A;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_pre_valid", resp_valid, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_drop", {resp_valid, init_done, req_ready, resp_rdata},
          {3'b000, 84'h0});
    do_sweep();
    do_read(7'h2A, "rst_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_array_driver.md
# sram_array_driver

Request-side controller for one 128-entry, 4-way, 84-bit single-port cache array macro (the RW0-style SRAM port). It zero-fills the array after reset and then serves one read or write at a time from a valid/ready request channel. Read data returns on a valid/ready response channel. The block sits between cache pipeline logic and the array macro and absorbs the macro's one-cycle read latency.

## Interface
- DEPTH, 128: number of array entries.
- ADDR_W, 7: address width; must satisfy 2^ADDR_W == DEPTH.
- WAYS, 4: write-mask width, one bit per way.
- WAY_W, 21: bits per way.
- DATA_W, 84: WAYS*WAY_W.

- clock  in  1  single clock for the block and the array.
- reset  in  1  synchronous, active-high.
- init_done  out  1  high once the zero-fill has finished; stays high until the next reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  entry index.
- req_wdata  in  DATA_W  write data; way i occupies [i*WAY_W +: WAY_W].
- req_wmask  in  WAYS  per-way write enable.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  registered read data.
- RW0_addr  out  ADDR_W  array address.
- RW0_en  out  1  array enable.
- RW0_clk  out  1  equals clock.
- RW0_wmode  out  1  1 = write.
- RW0_wdata  out  DATA_W  array write data.
- RW0_wmask  out  WAYS  array way mask.
- RW0_rdata  in  DATA_W  array read data; valid the cycle after a read-enable.

## Operation
- FSM states:
  - INIT: zero-fill sweep.
  - IDLE: accepts requests.
  - RD: array output is being captured.
  - RESP: holding the response.
- Reset puts the FSM in INIT, clears the fill counter, and drives init_done=0, req_ready=0, resp_valid=0, resp_rdata=0.
- INIT, each cycle:
  - Drive RW0_en=1, RW0_wmode=1, RW0_addr=counter, RW0_wdata=0, RW0_wmask=all ones.
  - Increment the counter.
  - After writing address DEPTH-1, go to IDLE and set init_done=1.
  - The counter must not wrap back into another sweep.
- IDLE:
  - req_ready=1.
  - On req_valid, RW0_en=1 and RW0_addr=req_addr, combinationally in the same cycle.
  - Write: RW0_wmode=1 and pass wdata/wmask through; stay in IDLE; no response is produced.
  - Write with req_wmask=0: still pulses RW0_en with wmode=1; the array stays unchanged.
  - Read: RW0_wmode=0, RW0_wmask=0; go to RD.
- RD:
  - req_ready=0 and RW0_en=0.
  - Capture RW0_rdata into resp_rdata at the end of the cycle; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata is held stable.
  - req_ready=0 and RW0_en=0.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle.
- When RW0_en=0, RW0_addr/wdata/wmask/wmode are don't-care but must be 0.
- Simultaneous events:
  - The response handshake in RESP and a new req_valid cannot overlap, because req_ready=0 in RESP.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Reset mid-operation (any state, including RESP with resp_valid high):
  - Abandon the state and drop any pending response without a handshake.
  - Restart the full INIT sweep from address 0.

## Timing
- Zero-fill: DEPTH cycles. For the cycle count, the first cycle with reset low is cycle 0. With DEPTH=128, RW0_en is high in cycles 0..127 and init_done is first high in cycle 128.
- Read accepted in cycle T:
  - Array enable in cycle T.
  - RW0_rdata sampled in cycle T+1.
  - resp_valid high from T+2.
  - Earliest next acceptance: T+3, with resp_ready held high.
- Write accepted in cycle T: the array is written at the end of T. Back-to-back writes are allowed, one per cycle.
- A read issued the cycle after a write to the same address returns the new data, because the array commits writes at the clock edge.
- Only resp_rdata, state, counter and init_done are flops. RW0_* and req_ready are decoded from state plus the request inputs.

## Test plan
- Reset release, then count enables:
  - Exactly 128 RW0_en cycles with wmode=1, wdata=0, wmask=4'hF, addresses 0..127 in order.
  - init_done rises at cycle 128.
  - req_ready is 0 throughout the sweep.
- After init, read address 5 -> resp_rdata=0, resp_valid at T+2.
- Write address 0x2A, data 84'h123456789ABCDEF012345, mask 4'hF, then read 0x2A -> the same value comes back.
- Partial write, using the prior contents of 0x2A:
  - Write address 0x2A with data all ones and mask 4'b0101.
  - Then read 0x2A -> ways 0 and 2 = 21'h1FFFFF; ways 1 and 3 keep their prior contents.
- Back-pressure:
  - Read, then hold resp_ready=0 for 10 cycles -> resp_valid stays 1, resp_rdata stays stable, req_ready stays 0, no RW0_en.
  - Release resp_ready -> the next request is accepted one cycle later.
- Assert reset while in RESP:
  - resp_valid=0 the cycle after reset.
  - After release, a full 128-cycle sweep runs.
  - A read of the previously written 0x2A returns 0.
